// File: rtl/rcv_arbiter.sv
// Round-robin arbiter sharing one registered byte port between two REQ/ACK receive channels.
// Optional grant counters (cnt0/cnt1) are built when RCV_ARB_STATS_EN is defined.
module rcv_arbiter #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TMR_W   = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req0,
  input  logic [DATA_W-1:0] data0,
  output logic              ack0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data1,
  output logic              ack1,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ch,
  input  logic              out_ready,
  output logic [1:0]        hs_err,
  input  logic              err_clr
`ifdef RCV_ARB_STATS_EN
  ,
  output logic [15:0]       cnt0,
  output logic [15:0]       cnt1
`endif
);

  localparam logic [TMR_W-1:0] TimeoutLast = TMR_W'(TIMEOUT - 1);

  typedef enum logic [0:0] {StIdle, StWaitRel} state_e;

  state_e              state_q, state_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_ch_q, out_ch_d;
  logic [1:0]          hs_err_q, hs_err_d;
  logic                last_grant_q, last_grant_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
`ifdef RCV_ARB_STATS_EN
  logic [15:0]         cnt0_q, cnt0_d;
  logic [15:0]         cnt1_q, cnt1_d;
`endif

  logic slot_free;
  logic grant;
  logic gnt_ch;
  logic granted_req;
  logic timeout_hit;

  // The slot can be refilled in the same cycle the consumer takes the current byte.
  assign slot_free   = ~out_valid_q | out_ready;
  assign grant       = (state_q == StIdle) & slot_free & (req0 | req1);
  assign gnt_ch      = (req0 & req1) ? ~last_grant_q : req1;
  assign granted_req = last_grant_q ? req1 : req0;
  assign timeout_hit = (timer_q == TimeoutLast);

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q      <= StIdle;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_ch_q     <= 1'b0;
      hs_err_q     <= 2'b00;
      last_grant_q <= 1'b1;
      timer_q      <= '0;
`ifdef RCV_ARB_STATS_EN
      cnt0_q       <= 16'd0;
      cnt1_q       <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_ch_q     <= out_ch_d;
      hs_err_q     <= hs_err_d;
      last_grant_q <= last_grant_d;
      timer_q      <= timer_d;
`ifdef RCV_ARB_STATS_EN
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (grant) state_d = StWaitRel;
      end
      StWaitRel: begin
        if (!granted_req || timeout_hit) state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    ack0_d       = ack0_q;
    ack1_d       = ack1_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_ch_d     = out_ch_q;
    hs_err_d     = hs_err_q;
    last_grant_d = last_grant_q;
    timer_d      = timer_q;
`ifdef RCV_ARB_STATS_EN
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
`endif

    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    // A timeout below overrides this clear for its own bit.
    if (err_clr) hs_err_d = 2'b00;

    unique case (state_q)
      StIdle: begin
        if (grant) begin
          out_valid_d  = 1'b1;
          out_data_d   = gnt_ch ? data1 : data0;
          out_ch_d     = gnt_ch;
          ack0_d       = ~gnt_ch;
          ack1_d       = gnt_ch;
          last_grant_d = gnt_ch;
          timer_d      = '0;
`ifdef RCV_ARB_STATS_EN
          if (gnt_ch) cnt1_d = cnt1_q + 16'd1;
          else        cnt0_d = cnt0_q + 16'd1;
`endif
        end
      end
      StWaitRel: begin
        if (!granted_req) begin
          ack0_d = 1'b0;
          ack1_d = 1'b0;
        end else if (timeout_hit) begin
          ack0_d                 = 1'b0;
          ack1_d                 = 1'b0;
          hs_err_d[last_grant_q] = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
    endcase
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign hs_err    = hs_err_q;
`ifdef RCV_ARB_STATS_EN
  assign cnt0      = cnt0_q;
  assign cnt1      = cnt1_q;
`endif

endmodule
